// File: rtl/pkg_cpu.sv
// -----------------------------------------------------------------------------
// pkg_cpu
// Shared CPU-side definitions: memory access size encodings, the state type of
// the CPU memory initiator and its default access timeout.
// No ports (package).
// -----------------------------------------------------------------------------
package pkg_cpu;

  // Access size encodings as seen on cpu_req_sz / data_acc_sz
  localparam logic cpu_data_acc_sz_8  = 1'b0;
  localparam logic cpu_data_acc_sz_16 = 1'b1;

  // Default number of WAIT cycles before an access is abandoned
  localparam int cpu_mem_timeout_default = 15;

  typedef enum logic [1:0] {IDLE, ARM, WAIT, RECOVER} cpu_mem_init_state;

  // Select the load result by access size; 8-bit loads are zero-extended
  function automatic logic [15:0] cpu_load_extend(input logic       sz,
                                                  input logic [7:0]  d8,
                                                  input logic [15:0] d16);
    return (sz == cpu_data_acc_sz_8) ? {8'h00, d8} : d16;
  endfunction

endpackage

// File: rtl/cpu_mem_initiator.sv
// -----------------------------------------------------------------------------
// cpu_mem_initiator
// CPU-side master for the req_rdwr / data_ready memory handshake. Takes one
// load/store at a time from the core, drives it onto the memory port, waits
// for data_ready (or a timeout) and answers with a one-cycle response pulse.
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   cpu_req_*                  core request: valid/ready, addr, write, sz, wdata
//   cpu_rsp_*                  core response: valid pulse, rdata, err (timeout)
//   busy                       high whenever the initiator is not idle
//   req_rdwr, addr_out,
//   write_data_out_8/16,
//   data_acc_sz,
//   write_data_we_8/16         memory-side request outputs
//   read_data_in_8/16,
//   data_ready                 memory-side read data and completion
// All outputs are registered.
// -----------------------------------------------------------------------------
module cpu_mem_initiator
  import pkg_cpu::*;
#(
  parameter int TIMEOUT_CYCLES = cpu_mem_timeout_default
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [15:0] cpu_req_addr,
  input  logic        cpu_req_write,
  input  logic        cpu_req_sz,
  input  logic [15:0] cpu_req_wdata,
  output logic        cpu_rsp_valid,
  output logic [15:0] cpu_rsp_rdata,
  output logic        cpu_rsp_err,
  output logic        busy,
  output logic        req_rdwr,
  output logic [15:0] addr_out,
  output logic [7:0]  write_data_out_8,
  output logic [15:0] write_data_out_16,
  output logic        data_acc_sz,
  output logic        write_data_we_8,
  output logic        write_data_we_16,
  input  logic [7:0]  read_data_in_8,
  input  logic [15:0] read_data_in_16,
  input  logic        data_ready
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  cpu_mem_init_state state_q;

  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        req_rdwr_q;
  logic [15:0] addr_q;
  logic [7:0]  wd8_q;
  logic [15:0] wd16_q;
  logic        sz_q;
  logic        we8_q;
  logic        we16_q;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_d;
  logic        timeout_hit;

  // Saturating wait counter; the limit is checked against the value this
  // WAIT edge would store, so TIMEOUT_CYCLES=1 fails on the first WAIT edge.
  assign cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout_hit = (cnt_d >= TIMEOUT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= 16'h0000;
      busy_q      <= 1'b0;
      req_rdwr_q  <= 1'b0;
      addr_q      <= 16'h0000;
      wd8_q       <= 8'h00;
      wd16_q      <= 16'h0000;
      sz_q        <= 1'b0;
      we8_q       <= 1'b0;
      we16_q      <= 1'b0;
      cnt_q       <= 8'h00;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready comes up one edge after reset release; a request is only
          // taken on an edge where the core could already see ready high
          if (ready_q && cpu_req_valid) begin
            addr_q     <= cpu_req_addr;
            sz_q       <= cpu_req_sz;
            wd8_q      <= cpu_req_wdata[7:0];
            wd16_q     <= cpu_req_wdata;
            we8_q      <= cpu_req_write && (cpu_req_sz == cpu_data_acc_sz_8);
            we16_q     <= cpu_req_write && (cpu_req_sz == cpu_data_acc_sz_16);
            req_rdwr_q <= 1'b1;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            state_q    <= ARM;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ARM: begin
          // data_ready may still be high from the previous access; skip it
          cnt_q   <= 8'h00;
          state_q <= WAIT;
        end
        WAIT: begin
          if (data_ready) begin
            rdata_q     <= (we8_q || we16_q) ? 16'h0000
                         : cpu_load_extend(sz_q, read_data_in_8, read_data_in_16);
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            req_rdwr_q  <= 1'b0;
            state_q     <= RECOVER;
          end else begin
            cnt_q <= cnt_d;
            if (timeout_hit) begin
              rdata_q     <= 16'h0000;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              req_rdwr_q  <= 1'b0;
              state_q     <= RECOVER;
            end
          end
        end
        RECOVER: begin
          // address/data/size were left untouched so a trailing memory access
          // repeats the same operation; only the enables are dropped now
          we8_q   <= 1'b0;
          we16_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready     = ready_q;
  assign cpu_rsp_valid     = rsp_valid_q;
  assign cpu_rsp_rdata     = rdata_q;
  assign cpu_rsp_err       = rsp_err_q;
  assign busy              = busy_q;
  assign req_rdwr          = req_rdwr_q;
  assign addr_out          = addr_q;
  assign write_data_out_8  = wd8_q;
  assign write_data_out_16 = wd16_q;
  assign data_acc_sz       = sz_q;
  assign write_data_we_8   = we8_q;
  assign write_data_we_16  = we16_q;

endmodule

// File: doc/cpu_mem_initiator.md
Name: cpu_mem_initiator

Overview:
- CPU-side master for the tb_memory-style req_rdwr / data_ready handshake.
- Accepts one load/store request at a time from the CPU core.
- Drives address, data, size and write enables to memory, then waits for data_ready.
- Returns read data, or an error on timeout, to the core as a one-cycle response pulse.

Parameters:
TIMEOUT_CYCLES, 15, max cycles in WAIT before the access is aborted with an error (1..255)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
cpu_req_valid  input  1  core presents a request
cpu_req_ready  output  1  block can accept a request (high only in IDLE)
cpu_req_addr  input  16  byte address
cpu_req_write  input  1  1 = store, 0 = load
cpu_req_sz  input  1  pkg_cpu::cpu_data_acc_sz_8 or cpu_data_acc_sz_16
cpu_req_wdata  input  16  store data; only [7:0] is used for 8-bit stores
cpu_rsp_valid  output  1  one-cycle completion pulse
cpu_rsp_rdata  output  16  load data, 8-bit loads zero-extended; 0 for stores and errors
cpu_rsp_err  output  1  qualifies cpu_rsp_valid: timeout occurred
busy  output  1  high whenever state is not IDLE
req_rdwr  output  1  memory request
addr_out  output  16  memory address
write_data_out_8  output  8  8-bit store data
write_data_out_16  output  16  16-bit store data
data_acc_sz  output  1  access size
write_data_we_8  output  1  8-bit write enable
write_data_we_16  output  1  16-bit write enable
read_data_in_8  input  8  8-bit read data from memory
read_data_in_16  input  16  16-bit read data from memory
data_ready  input  1  memory completion, registered by memory

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous and active-high, on port reset.
- Outputs: all registered. On reset every output is 0 and state is IDLE.
- States:
  - IDLE: cpu_req_ready=1. When cpu_req_valid=1, latch the request into the memory-side outputs. Set req_rdwr<=1; set we_8 only for an 8-bit write and we_16 only for a 16-bit write (never both). Go to ARM.
  - ARM: exactly one cycle. data_ready is ignored here, because it may be stale-high from the previous access. Go to WAIT and clear the timeout counter.
  - WAIT: on data_ready=1:
    - capture read_data_in_8 (zero-extended) or read_data_in_16 by data_acc_sz; stores capture 0;
    - cpu_rsp_valid<=1, err<=0, req_rdwr<=0; go to RECOVER.
    - Otherwise the counter increments. When it reaches TIMEOUT_CYCLES: cpu_rsp_valid<=1, err<=1, rdata<=0, req_rdwr<=0; go to RECOVER.
  - RECOVER: one cycle. addr_out, write data, data_acc_sz and write enables stay unchanged, so a trailing repeated memory access is identical and harmless. Then go to IDLE and clear the write enables.
- Response signals: cpu_rsp_valid is high exactly one cycle, the cycle in RECOVER. cpu_rsp_rdata holds its value until the next response.
- Latency: with a 2-cycle memory, the start edge is E0 and data_ready is sampled high at E3. cpu_rsp_valid is high between E3 and E4. The next request is accepted at E5 at the earliest.
- Requests while not IDLE: cpu_req_valid is ignored. The core must hold the request until it sees cpu_req_ready at a sampling edge.
- Reset mid-access: everything returns to IDLE immediately, req_rdwr drops asynchronously, and no response is issued.
- Counter: 8-bit, saturating. TIMEOUT_CYCLES=1 means error if data_ready is not seen on the first WAIT edge.

Decomposition:
- pkg_cpu gains:
  - typedef enum logic [1:0] cpu_mem_init_state {IDLE, ARM, WAIT, RECOVER};
  - localparam cpu_mem_timeout_default=15.
- Size constants are reused from pkg_cpu.
- No sub-module needed; the timeout counter is inline.

Test Plan:
- Pairing with tb_memory, mem[0x0010]=0xAB: 8-bit load of 0x0010 -> cpu_rsp_rdata=0x00AB, err=0, rsp_valid 3 cycles after acceptance; write enables stay 0.
- 16-bit store of 0xBEEF at 0x0020, then 16-bit load of 0x0020 -> rdata=0xBEEF. we_16 is high only during ARM, WAIT and RECOVER; we_8 is never high.
- Back-to-back requests with cpu_req_valid held high -> second accepted exactly one cycle after RECOVER. Stale data_ready=1 during ARM does not complete the second access early.
- Stub memory that never asserts data_ready, TIMEOUT_CYCLES=15 -> rsp_valid=1, err=1, rdata=0 after 15 WAIT cycles; req_rdwr=0 afterwards.
- reset asserted during WAIT of a store -> req_rdwr, write enables and busy go to 0 immediately; no rsp_valid. After release, an 8-bit load of 0x0010 returns 0x00AB.
- cpu_req_valid pulsed while busy -> ignored; exactly one response is produced.
